// File: rtl/mod_mult_split_pkg.sv
// Shared Goldilocks-field constants and split-word payload for the multiply/reduce path.
package mod_mult_split_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned DWORD_W = 64;
    localparam int unsigned PROD_W  = 128;
    localparam int unsigned TAG_W   = 16;

    localparam logic [DWORD_W-1:0] GOLDILOCKS_P = 64'hFFFF_FFFF_0000_0001;

    // Product x split as {a,b,c,d} = {x[127:96], x[95:64], x[63:32], x[31:0]}
    typedef struct packed {
        logic [WORD_W-1:0] a;
        logic [WORD_W-1:0] b;
        logic [WORD_W-1:0] c;
        logic [WORD_W-1:0] d;
    } split_words_t;

    // One conditional subtract suffices since 2^64-1 < 2P
    function automatic logic [DWORD_W-1:0] canon64(input logic [DWORD_W-1:0] v);
        return (v >= GOLDILOCKS_P) ? (v - GOLDILOCKS_P) : v;
    endfunction

endpackage

// File: rtl/mod_mult_split_mul32x32_reg.sv
// Registered 32x32->64 unsigned multiplier with clock enable; sized to map onto one DSP tile.
module mul32x32_reg
    import mod_mult_split_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_en,
    input  logic [WORD_W-1:0]    i_a,
    input  logic [WORD_W-1:0]    i_b,
    output logic [DWORD_W-1:0]   o_p
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_p <= '0;
        end else if (i_en) begin
            o_p <= DWORD_W'(i_a) * DWORD_W'(i_b);
        end
    end

endmodule

// File: rtl/mod_mult_split.sv
// Three-stage 64x64 multiplier with operand canonicalisation mod p and 4x32-bit product split,
// feeding the Goldilocks fast-reduction stage. Valid/ready flow control, whole-pipe stall.
module mod_mult_split
    import mod_mult_split_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DWORD_W-1:0]   in_x,
    input  logic [DWORD_W-1:0]   in_y,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_W-1:0]    out_a,
    output logic [WORD_W-1:0]    out_b,
    output logic [WORD_W-1:0]    out_c,
    output logic [WORD_W-1:0]    out_d,
    output logic [TAG_W-1:0]     out_tag
);

    logic                 w_stall;
    logic                 w_en;

    logic                 r_v1;
    logic [DWORD_W-1:0]   r_x1;
    logic [DWORD_W-1:0]   r_y1;
    logic [TAG_W-1:0]     r_tag1;

    logic                 r_v2;
    logic [TAG_W-1:0]     r_tag2;
    logic [DWORD_W-1:0]   w_ll;
    logic [DWORD_W-1:0]   w_lh;
    logic [DWORD_W-1:0]   w_hl;
    logic [DWORD_W-1:0]   w_hh;

    logic [DWORD_W:0]     w_mid;
    logic [PROD_W-1:0]    w_prod;
    logic                 r_v3;
    logic [TAG_W-1:0]     r_tag3;
    split_words_t         r_words3;

    // Whole pipe freezes only when the output holds a word set the consumer refuses
    assign w_stall  = r_v3 & ~out_ready;
    assign w_en     = ~w_stall;
    assign in_ready = ~w_stall;

    // S1: canonicalised operands, tag and valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_x1   <= '0;
            r_y1   <= '0;
            r_tag1 <= '0;
        end else if (w_en) begin
            r_v1   <= in_valid;
            r_x1   <= canon64(in_x);
            r_y1   <= canon64(in_y);
            r_tag1 <= in_tag;
        end
    end

    // S2: four partial products
    mul32x32_reg u_mul_ll (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_en),
        .i_a   (r_x1[WORD_W-1:0]),
        .i_b   (r_y1[WORD_W-1:0]),
        .o_p   (w_ll)
    );

    mul32x32_reg u_mul_lh (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_en),
        .i_a   (r_x1[WORD_W-1:0]),
        .i_b   (r_y1[DWORD_W-1:WORD_W]),
        .o_p   (w_lh)
    );

    mul32x32_reg u_mul_hl (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_en),
        .i_a   (r_x1[DWORD_W-1:WORD_W]),
        .i_b   (r_y1[WORD_W-1:0]),
        .o_p   (w_hl)
    );

    mul32x32_reg u_mul_hh (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_en),
        .i_a   (r_x1[DWORD_W-1:WORD_W]),
        .i_b   (r_y1[DWORD_W-1:WORD_W]),
        .o_p   (w_hh)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2   <= 1'b0;
            r_tag2 <= '0;
        end else if (w_en) begin
            r_v2   <= r_v1;
            r_tag2 <= r_tag1;
        end
    end

    // S3: hh and ll do not overlap, so they concatenate; the 65-bit middle sum is added at bit 32
    assign w_mid  = (DWORD_W+1)'(w_lh) + (DWORD_W+1)'(w_hl);
    assign w_prod = {w_hh, w_ll} + {31'd0, w_mid, 32'd0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v3     <= 1'b0;
            r_tag3   <= '0;
            r_words3 <= '0;
        end else if (w_en) begin
            r_v3     <= r_v2;
            r_tag3   <= r_tag2;
            r_words3 <= split_words_t'(w_prod);
        end
    end

    assign out_valid = r_v3;
    assign out_a     = r_words3.a;
    assign out_b     = r_words3.b;
    assign out_c     = r_words3.c;
    assign out_d     = r_words3.d;
    assign out_tag   = r_tag3;

endmodule
